// File: rtl/pll_reconfig_seq_pkg.sv
// Shared types and the per-mode PLL register lists replayed by pll_reconfig_seq.
package pll_reconfig_pkg;

  localparam int PLL_NUM_MODES = 3;
  localparam int NUM_STEPS     = 6;

  localparam logic [5:0] PLL_REG_MODE  = 6'd0;
  localparam logic [5:0] PLL_REG_START = 6'd2;
  localparam logic [5:0] PLL_REG_N     = 6'd3;
  localparam logic [5:0] PLL_REG_M     = 6'd4;
  localparam logic [5:0] PLL_REG_C     = 6'd5;
  localparam logic [5:0] PLL_REG_K     = 6'd7;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } pll_wr_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_LOCK, S_FINISH} pll_state_t;

  // Mode register 0 selects waitrequest mode; C writes target C0 (data[22:18] = 0).
  localparam pll_wr_t PLL_TABLE [PLL_NUM_MODES][NUM_STEPS] = '{
    '{'{PLL_REG_MODE, 32'h0}, '{PLL_REG_N, 32'h0002_0404}, '{PLL_REG_M, 32'h0000_1B1B},
      '{PLL_REG_C, 32'h0000_0A0A}, '{PLL_REG_K, 32'h0000_0000}, '{PLL_REG_START, 32'h0}},
    '{'{PLL_REG_MODE, 32'h0}, '{PLL_REG_N, 32'h0000_0303}, '{PLL_REG_M, 32'h0002_1110},
      '{PLL_REG_C, 32'h0002_0908}, '{PLL_REG_K, 32'h1999_999A}, '{PLL_REG_START, 32'h0}},
    '{'{PLL_REG_MODE, 32'h0}, '{PLL_REG_N, 32'h0001_0101}, '{PLL_REG_M, 32'h0000_0C0C},
      '{PLL_REG_C, 32'h0000_0707}, '{PLL_REG_K, 32'h8000_0000}, '{PLL_REG_START, 32'h0}}
  };

endpackage

// File: rtl/pll_reconfig_seq.sv
// Replays a per-mode register list into the PLL reconfig port on a mode change,
// then waits for the PLL to release waitrequest and reports done/error.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_MODES = PLL_NUM_MODES,
  parameter int TIMEOUT   = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW:0] T_GUARD = (TW+1)'(2);
  localparam logic [TW:0] T_LAST  = (TW+1)'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

  pll_state_t    state;
  logic [1:0]    mode_q, pend_mode, m_sel;
  logic          pend_vld, ok_q;
  logic [2:0]    step, step_nxt;
  logic [TW-1:0] timer;
  logic [TW:0]   t_nxt;

  // A live req always beats a stored one: latest mode wins.
  assign m_sel    = req ? mode : pend_mode;
  assign step_nxt = step + 3'd1;
  assign t_nxt    = {1'b0, timer} + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      pend_mode      <= '0;
      pend_vld       <= 1'b0;
      ok_q           <= 1'b0;
      step           <= '0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (req && state != S_IDLE) begin
        pend_vld  <= 1'b1;
        pend_mode <= mode;
      end
      case (state)
        S_IDLE: begin
          if (req || pend_vld) begin
            pend_vld <= 1'b0;
            if (32'(m_sel) < NUM_MODES) begin
              mode_q         <= m_sel;
              step           <= '0;
              busy           <= 1'b1;
              mgmt_write     <= 1'b1;
              mgmt_address   <= PLL_TABLE[m_sel][0].addr;
              mgmt_writedata <= PLL_TABLE[m_sel][0].data;
              state          <= S_WRITE;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!mgmt_waitrequest) begin
            if (step == LAST_STEP) begin
              mgmt_write     <= 1'b0;
              mgmt_address   <= '0;
              mgmt_writedata <= '0;
              timer          <= '0;
              state          <= S_WAIT_LOCK;
            end else begin
              step           <= step_nxt;
              mgmt_address   <= PLL_TABLE[mode_q][step_nxt].addr;
              mgmt_writedata <= PLL_TABLE[mode_q][step_nxt].data;
            end
          end
        end
        S_WAIT_LOCK: begin
          // waitrequest is only trusted once the guard window has elapsed
          timer <= (timer == '1) ? timer : t_nxt[TW-1:0];
          if (t_nxt >= T_GUARD && !mgmt_waitrequest) begin
            ok_q  <= 1'b1;
            state <= S_FINISH;
          end else if (t_nxt >= T_LAST) begin
            ok_q  <= 1'b0;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          done  <= ok_q;
          error <= !ok_q;
          busy  <= 1'b0;
          timer <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: write order, stalls, bad mode, timeout, pending, reset abort.
module tb_pll_reconfig_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, done, error, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;

  int vecs = 0;
  int errs = 0;

  logic [5:0]  exp_addr [6] = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
  logic [31:0] exp_data [3][6] = '{
    '{32'h0, 32'h0002_0404, 32'h0000_1B1B, 32'h0000_0A0A, 32'h0000_0000, 32'h0},
    '{32'h0, 32'h0000_0303, 32'h0002_1110, 32'h0002_0908, 32'h1999_999A, 32'h0},
    '{32'h0, 32'h0001_0101, 32'h0000_0C0C, 32'h0000_0707, 32'h8000_0000, 32'h0}
  };

  pll_reconfig_seq #(.NUM_MODES(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .busy(busy), .done(done), .error(error),
    .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                                      input logic b, input logic dn, input logic er);
    return {w, a, d, b, dn, er};
  endfunction

  function automatic logic [41:0] obs();
    return {mgmt_write, mgmt_address, mgmt_writedata, busy, done, error};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vecs++;
    if (obs() !== 42'd0) begin
      errs++; $display("FAIL reset: got %h exp %h", obs(), 42'd0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mode0();
    logic [41:0] e;
    req = 1'b1; mode = 2'd0;
    tick(); req = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      mgmt_waitrequest = (c >= 7 && c <= 9);
      if (c <= 6)       e = bus(1'b1, exp_addr[c-1], exp_data[0][c-1], 1'b1, 1'b0, 1'b0);
      else if (c <= 11) e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 12) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      else              e = 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL mode0 c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic test_stall();
    logic [41:0] e;
    int k;
    req = 1'b1; mode = 2'd1;
    tick(); req = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      mgmt_waitrequest = (c >= 3 && c <= 6);
      k = (c <= 2) ? c - 1 : (c <= 7) ? 2 : c - 5;
      if (c <= 10)      e = bus(1'b1, exp_addr[k], exp_data[1][k], 1'b1, 1'b0, 1'b0);
      else if (c <= 13) e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 14) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      else              e = 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL stall c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic test_bad_mode();
    logic [41:0] e;
    req = 1'b1; mode = 2'd3;
    tick(); req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      e = (c == 1) ? bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1) : 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL bad_mode c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [41:0] e;
    req = 1'b1; mode = 2'd2;
    tick(); req = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      mgmt_waitrequest = (c >= 7);
      if (c <= 6)       e = bus(1'b1, exp_addr[c-1], exp_data[2][c-1], 1'b1, 1'b0, 1'b0);
      else if (c <= 22) e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 23) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      else              e = 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL timeout c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic test_pending();
    logic [41:0] e;
    req = 1'b1; mode = 2'd0;
    tick(); req = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      req  = (c == 3 || c == 5);
      mode = (c == 3) ? 2'd1 : 2'd2;
      if (c <= 6)       e = bus(1'b1, exp_addr[c-1], exp_data[0][c-1], 1'b1, 1'b0, 1'b0);
      else if (c <= 9)  e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 10) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      else if (c <= 16) e = bus(1'b1, exp_addr[c-11], exp_data[2][c-11], 1'b1, 1'b0, 1'b0);
      else if (c <= 19) e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 20) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      else              e = 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL pending c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [41:0] e;
    req = 1'b1; mode = 2'd1;
    tick(); req = 1'b0;
    tick();
    req = 1'b1; mode = 2'd2;  // becomes pending, must be discarded by reset
    tick(); req = 1'b0;
    tick();
    e = bus(1'b1, exp_addr[3], exp_data[1][3], 1'b1, 1'b0, 1'b0);
    vecs++;
    if (obs() !== e) begin
      errs++; $display("FAIL rst_mid_step3: got %h exp %h", obs(), e);
    end
    reset = 1'b1;
    #2;
    vecs++;
    if (obs() !== 42'd0) begin
      errs++; $display("FAIL rst_mid_async: got %h exp %h", obs(), 42'd0);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vecs++;
      if (obs() !== 42'd0) begin
        errs++; $display("FAIL rst_mid_idle c=%0d: got %h exp %h", c, obs(), 42'd0);
      end
    end
    req = 1'b1; mode = 2'd0;
    tick(); req = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 6)       e = bus(1'b1, exp_addr[c-1], exp_data[0][c-1], 1'b1, 1'b0, 1'b0);
      else if (c <= 9)  e = bus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 10) e = bus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      else              e = 42'd0;
      vecs++;
      if (obs() !== e) begin
        errs++; $display("FAIL rst_mid_restart c=%0d: got %h exp %h", c, obs(), e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_stall();
    test_bad_mode();
    test_timeout();
    test_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Sequencer that reprograms the video PLL through the `pll_cfg` management port when the video mode changes (NTSC/PAL/alternate timings). It accepts a one-cycle request carrying a mode index, then replays a fixed per-mode register list (mode, N, M, C0, K, start) as Avalon-MM writes, honouring `mgmt_waitrequest`. It waits for the PLL to finish (waitrequest released after start), and reports done or timeout. It sits in the `CLK_50M` domain between the system's video-mode logic and `pll_cfg`, replacing the ad-hoc single-write edge detector.

## Interface
- `NUM_MODES`, 3: number of valid mode entries in the package table.
- `TIMEOUT`, 1048576: maximum cycles to wait for PLL completion after the start write.
- `clk` in 1: management clock (50 MHz). One clock.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: one-cycle request to reconfigure.
- `mode` in 2: mode index, sampled with `req`.
- `busy` out 1: high from the accepted request until done or error.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on bad mode or timeout.
- `mgmt_write` out 1: Avalon write strobe to `pll_cfg`.
- `mgmt_address` out 6: register address.
- `mgmt_writedata` out 32: register data.
- `mgmt_waitrequest` in 1: Avalon waitrequest from `pll_cfg`.

## Operation
- States: IDLE, WRITE, WAIT_LOCK, FINISH.
- **IDLE**
  - On `req` with `mode < NUM_MODES`: latch the mode, `step := 0`, set `busy`, and go to WRITE.
  - On `req` with `mode >= NUM_MODES`: pulse `error`, stay in IDLE, issue no writes.
- **WRITE**
  - Drive `mgmt_write=1` with address and data from `PLL_TABLE[mode][step]`.
  - A write is accepted when `mgmt_write & ~mgmt_waitrequest`.
  - While waitrequest is high, hold address and data stable.
  - On acceptance at step < 5: `step++` and stay in WRITE.
  - On acceptance at step 5 (start register, address 2): go to WAIT_LOCK.
- Fixed step order: address 0 (mode register, data 0 = waitrequest mode), then 3 (N), 4 (M), 5 (C0, counter select in data[22:18]), 7 (K), 2 (start, data 0).
- **WAIT_LOCK**
  - `mgmt_write=0`; the timer counts from 0.
  - Ignore waitrequest for the first 2 cycles (guards against a late assertion).
  - Afterwards, waitrequest low ends the wait: go to FINISH with ok status.
  - If the timer reaches `TIMEOUT-1` with waitrequest still high: go to FINISH with error status.
- **FINISH**: pulse `done` or `error` for one cycle, clear `busy`, return to IDLE.
- A `req` arriving while busy is stored as a pending request; the latest mode wins. It is serviced in the first IDLE cycle after FINISH, exactly as if asserted then.
- Timer width is `$clog2(TIMEOUT)`; it saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, `busy=0`, `done=0`, `error=0`, `mgmt_write=0`
  - `mgmt_address=0`, `mgmt_writedata=0`
  - pending cleared, timer 0
- All outputs are registered.
- Request latency: `req` at cycle T gives `mgmt_write=1` (step 0) at T+1.
- Writes run back-to-back: step k accepted at cycle C puts step k+1 on the bus at C+1, with no idle gap.
- With waitrequest never asserted during writes, the start write is accepted at T+6.
- Fastest completion: WAIT_LOCK spans T+7..T+8 and `done` pulses at T+10.
- `busy` rises at T+1 and falls in the same cycle `done` or `error` pulses.
- Bad-mode `error` pulses at T+1, and `busy` stays 0.
- Asserting `reset` mid-sequence aborts immediately: `mgmt_write` drops asynchronously and the pending request is discarded.

## Structure
- Package `pll_reconfig_pkg`:
  - `pll_wr_t` struct {addr[5:0], data[31:0]}
  - `NUM_STEPS=6`
  - `PLL_TABLE[NUM_MODES][NUM_STEPS]` per-mode constants
  - address localparams `PLL_REG_MODE/START/N/M/C/K`
  - state enum
- No sub-module. The table is a constant ROM indexed combinationally and registered onto the bus.

## Test plan
- **Mode 0, no waitrequest:**
  - `req`, `mode=0`.
  - Expect addresses 0,3,4,5,7,2 on six consecutive cycles with the `PLL_TABLE[0]` data.
  - Hold waitrequest high 3 cycles after start, then low: `done` fires exactly once, `busy` spans the whole sequence.
- **Stall on the M write:** waitrequest high for 4 cycles during step 2 → address 4 and its data held stable 5 cycles, `mgmt_write` held; the remaining writes follow unchanged.
- **Bad mode:** `req`, `mode=3` → `error` at T+1, zero writes, `busy` never high.
- **Timeout:** `TIMEOUT=16`, waitrequest stuck high after start → `error` pulse 16 cycles after entering WAIT_LOCK, then IDLE.
- **Pending request:** `req` mode 1 during a mode 0 sequence, then `req` mode 2 → after mode 0 `done`, exactly one mode 2 sequence runs.
- **Reset mid-sequence:** assert `reset` during step 3 → all outputs 0 at once, state IDLE; the next `req` restarts from step 0.
